// File: rtl/utf_stream_pkg.sv
// Shared constants and types for the code point to byte stream encoder.
package utf_stream_pkg;

    // Output encoding selected per code point at accept time
    localparam logic [1:0] MODE_UTF8    = 2'd0;
    localparam logic [1:0] MODE_UTF16LE = 2'd1;
    localparam logic [1:0] MODE_UTF16BE = 2'd2;
    localparam logic [1:0] MODE_UTF32BE = 2'd3;

    // UTF-8 sequence-length thresholds (value must be below the limit)
    localparam logic [31:0] UTF8_LIM1 = 32'h0000_0080;
    localparam logic [31:0] UTF8_LIM2 = 32'h0000_0800;
    localparam logic [31:0] UTF8_LIM3 = 32'h0001_0000;
    localparam logic [31:0] UTF8_LIM4 = 32'h0020_0000;
    localparam logic [31:0] UTF8_LIM5 = 32'h0400_0000;

    // Unicode range limits
    localparam logic [31:0] SURR_LO   = 32'h0000_D800;
    localparam logic [31:0] SURR_HI   = 32'h0000_DFFF;
    localparam logic [31:0] CP_MAX    = 32'h0010_FFFF;
    localparam logic [31:0] SUPP_BASE = 32'h0001_0000;

    // Default substitute for invalid input
    localparam logic [31:0] REPL_CP_DEF = 32'h0000_FFFD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } enc_state_t;

endpackage

// File: rtl/utf_seq_pack.sv
// Combinational packer: validates a code point and builds its byte sequence,
// left-aligned in transmit order, together with the sequence length.
module utf_seq_pack
    import utf_stream_pkg::*;
#(
    parameter logic [31:0] REPL_CP = REPL_CP_DEF
) (
    input  logic [31:0] cp,
    input  logic [1:0]  mode,
    input  logic        chk_range,
    output logic        repl,
    output logic [2:0]  len,
    output logic [47:0] seq
);

    logic        is_utf16;
    logic        over_max;
    logic        is_surr;
    logic [31:0] v;
    logic [31:0] v_off;
    logic [15:0] hi_unit;
    logic [15:0] lo_unit;

    assign is_utf16 = (mode == MODE_UTF16LE) || (mode == MODE_UTF16BE);
    assign over_max = (cp > CP_MAX);
    assign is_surr  = (cp >= SURR_LO) && (cp <= SURR_HI);
    assign repl     = cp[31] || (chk_range && (over_max || is_surr)) || (is_utf16 && over_max);
    assign v        = repl ? REPL_CP : cp;
    assign v_off    = v - SUPP_BASE;
    assign hi_unit  = 16'hD800 | {6'd0, v_off[19:10]};
    assign lo_unit  = 16'hDC00 | {6'd0, v_off[9:0]};

    // Select length and byte layout for the sampled mode
    always_comb begin
        len = 3'd1;
        seq = 48'd0;
        case (mode)
            MODE_UTF8: begin
                if (v < UTF8_LIM1) begin
                    len = 3'd1;
                    seq = {1'b0, v[6:0], 40'd0};
                end else if (v < UTF8_LIM2) begin
                    len = 3'd2;
                    seq = {3'b110, v[10:6], 2'b10, v[5:0], 32'd0};
                end else if (v < UTF8_LIM3) begin
                    len = 3'd3;
                    seq = {4'b1110, v[15:12], 2'b10, v[11:6], 2'b10, v[5:0], 24'd0};
                end else if (v < UTF8_LIM4) begin
                    len = 3'd4;
                    seq = {5'b11110, v[20:18], 2'b10, v[17:12], 2'b10, v[11:6],
                           2'b10, v[5:0], 16'd0};
                end else if (v < UTF8_LIM5) begin
                    len = 3'd5;
                    seq = {6'b111110, v[25:24], 2'b10, v[23:18], 2'b10, v[17:12],
                           2'b10, v[11:6], 2'b10, v[5:0], 8'd0};
                end else begin
                    len = 3'd6;
                    seq = {7'b1111110, v[30], 2'b10, v[29:24], 2'b10, v[23:18],
                           2'b10, v[17:12], 2'b10, v[11:6], 2'b10, v[5:0]};
                end
            end
            MODE_UTF16LE: begin
                if (v < SUPP_BASE) begin
                    len = 3'd2;
                    seq = {v[7:0], v[15:8], 32'd0};
                end else begin
                    len = 3'd4;
                    seq = {hi_unit[7:0], hi_unit[15:8], lo_unit[7:0], lo_unit[15:8], 16'd0};
                end
            end
            MODE_UTF16BE: begin
                if (v < SUPP_BASE) begin
                    len = 3'd2;
                    seq = {v[15:0], 32'd0};
                end else begin
                    len = 3'd4;
                    seq = {hi_unit, lo_unit, 16'd0};
                end
            end
            default: begin
                len = 3'd4;
                seq = {v, 16'd0};
            end
        endcase
    end

endmodule

// File: rtl/utf_stream_encoder.sv
// Streaming encoder: accepts code points, emits their UTF byte sequences one
// byte per cycle, replaces invalid input and counts replacements.
module utf_stream_encoder
    import utf_stream_pkg::*;
#(
    parameter int          ERR_W   = 8,
    parameter logic [31:0] REPL_CP = REPL_CP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cp_valid,
    output logic             cp_ready,
    input  logic [31:0]      cp_data,
    input  logic [1:0]       mode,
    input  logic             chk_range,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       byte_data,
    output logic             byte_first,
    output logic             byte_last,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);

    enc_state_t  state_q, state_d;
    logic [47:0] sr_p1;
    logic [2:0]  rem_p1;
    logic        first_p1;
    logic        pk_repl;
    logic [2:0]  pk_len;
    logic [47:0] pk_seq;
    logic        accept;
    logic        xfer;

    utf_seq_pack #(.REPL_CP(REPL_CP)) u_pack (
        .cp        (cp_data),
        .mode      (mode),
        .chk_range (chk_range),
        .repl      (pk_repl),
        .len       (pk_len),
        .seq       (pk_seq)
    );

    assign byte_valid = (state_q == ST_EMIT);
    assign busy       = byte_valid;
    assign byte_data  = sr_p1[47:40];
    assign byte_first = byte_valid && first_p1;
    assign byte_last  = byte_valid && (rem_p1 == 3'd1);
    assign xfer       = byte_valid && byte_ready;
    assign cp_ready   = (state_q == ST_IDLE) || (byte_last && byte_ready);
    assign accept     = cp_valid && cp_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: a new accept always (re)enters EMIT, else the last transfer ends it
    always_comb begin
        state_d = state_q;
        if (accept)                 state_d = ST_EMIT;
        else if (xfer && byte_last) state_d = ST_IDLE;
    end

    // Shift register, remaining-byte count and first-byte flag
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_p1    <= 48'd0;
            rem_p1   <= 3'd0;
            first_p1 <= 1'b0;
        end else if (accept) begin
            sr_p1    <= pk_seq;
            rem_p1   <= pk_len;
            first_p1 <= 1'b1;
        end else if (xfer && !byte_last) begin
            sr_p1    <= {sr_p1[39:0], 8'd0};
            rem_p1   <= rem_p1 - 3'd1;
            first_p1 <= 1'b0;
        end
    end

    // Replacement pulse and saturating replacement counter
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= accept && pk_repl;
            if (accept && pk_repl && !(&err_count))
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_utf_stream_encoder.sv
// Directed bench for utf_stream_encoder with hand-computed byte sequences.
module tb_utf_stream_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cp_valid;
    logic        cp_ready;
    logic [31:0] cp_data;
    logic [1:0]  mode;
    logic        chk_range;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_first;
    logic        byte_last;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    utf_stream_encoder #(.ERR_W(8), .REPL_CP(32'h0000FFFD)) dut (
        .clk        (clk),
        .rst        (rst),
        .cp_valid   (cp_valid),
        .cp_ready   (cp_ready),
        .cp_data    (cp_data),
        .mode       (mode),
        .chk_range  (chk_range),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .byte_first (byte_first),
        .byte_last  (byte_last),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one code point and wait (bounded) until it is accepted
    task automatic send_cp(input logic [31:0] cp, input logic [1:0] m, input logic c);
        int k;
        cp_data   = cp;
        mode      = m;
        chk_range = c;
        cp_valid  = 1'b1;
        k = 0;
        while (!cp_ready && k < 20) begin
            step();
            k++;
        end
        check("accept_wait", {63'd0, cp_ready}, 64'd1);
        step();
        cp_valid  = 1'b0;
        cp_data   = 32'hDEAD_BEEF;
        mode      = ~m;
        chk_range = ~c;
    endtask

    // Check n bytes streamed with byte_ready=1, left-aligned in exp
    task automatic recv(input string tag, input logic [47:0] exp, input int n, input logic exp_err);
        logic [47:0] e;
        e = exp;
        check({tag, "_errp"}, {63'd0, err_pulse}, {63'd0, exp_err});
        for (int i = 0; i < n; i++) begin
            check({tag, "_vld"},   {63'd0, byte_valid}, 64'd1);
            check({tag, "_data"},  {56'd0, byte_data}, {56'd0, e[47:40]});
            check({tag, "_first"}, {63'd0, byte_first}, {63'd0, (i == 0)});
            check({tag, "_last"},  {63'd0, byte_last}, {63'd0, (i == n - 1)});
            if (i == n - 1) check({tag, "_rdy_last"}, {63'd0, cp_ready}, 64'd1);
            e = {e[39:0], 8'd0};
            step();
        end
        check({tag, "_idle"}, {63'd0, byte_valid}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cp_valid   = 1'b0;
        cp_data    = 32'd0;
        mode       = 2'd0;
        chk_range  = 1'b0;
        byte_ready = 1'b1;
        step();
        step();
        check("rst_vld",   {63'd0, byte_valid}, 64'd0);
        check("rst_data",  {56'd0, byte_data}, 64'd0);
        check("rst_first", {63'd0, byte_first}, 64'd0);
        check("rst_last",  {63'd0, byte_last}, 64'd0);
        check("rst_errp",  {63'd0, err_pulse}, 64'd0);
        check("rst_errc",  {56'd0, err_count}, 64'd0);
        check("rst_busy",  {63'd0, busy}, 64'd0);
        check("rst_cprdy", {63'd0, cp_ready}, 64'd1);
        rst = 1'b0;
        step();

        send_cp(32'h41, 2'd0, 1'b1);
        recv("ascii", 48'h41_0000000000, 1, 1'b0);

        // Euro sign with a 3-cycle sink stall on the middle byte
        send_cp(32'h20AC, 2'd0, 1'b1);
        check("euro_b0", {56'd0, byte_data}, 64'hE2);
        check("euro_f0", {63'd0, byte_first}, 64'd1);
        step();
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("euro_stall_data", {56'd0, byte_data}, 64'h82);
            check("euro_stall_vld",  {63'd0, byte_valid}, 64'd1);
            check("euro_stall_last", {63'd0, byte_last}, 64'd0);
            check("euro_stall_rdy",  {63'd0, cp_ready}, 64'd0);
            step();
        end
        byte_ready = 1'b1;
        check("euro_b1", {56'd0, byte_data}, 64'h82);
        check("euro_first_clr", {63'd0, byte_first}, 64'd0);
        step();
        check("euro_b2", {56'd0, byte_data}, 64'hAC);
        check("euro_l2", {63'd0, byte_last}, 64'd1);
        step();
        check("euro_idle", {63'd0, byte_valid}, 64'd0);

        send_cp(32'h1F600, 2'd1, 1'b1);
        recv("u16le", 48'h3DD800DE_0000, 4, 1'b0);
        send_cp(32'h1F600, 2'd2, 1'b1);
        recv("u16be", 48'hD83DDE00_0000, 4, 1'b0);
        send_cp(32'h1F600, 2'd3, 1'b1);
        recv("u32be", 48'h0001F600_0000, 4, 1'b0);

        send_cp(32'hD800, 2'd0, 1'b1);
        recv("surr_strict", 48'hEFBFBD_000000, 3, 1'b1);
        check("surr_strict_cnt", {56'd0, err_count}, 64'd1);
        send_cp(32'hD800, 2'd0, 1'b0);
        recv("surr_loose", 48'hEDA080_000000, 3, 1'b0);
        check("surr_loose_cnt", {56'd0, err_count}, 64'd1);

        send_cp(32'h7FFFFFFF, 2'd0, 1'b0);
        recv("six_byte", 48'hFDBFBFBFBFBF, 6, 1'b0);
        check("six_byte_cnt", {56'd0, err_count}, 64'd1);
        send_cp(32'h80000000, 2'd0, 1'b0);
        recv("top_bit", 48'hEFBFBD_000000, 3, 1'b1);
        check("top_bit_cnt", {56'd0, err_count}, 64'd2);

        // Beyond U+10FFFF is always replaced in UTF-16
        send_cp(32'h110000, 2'd1, 1'b0);
        recv("u16_over", 48'hFDFF_00000000, 2, 1'b1);
        check("u16_over_cnt", {56'd0, err_count}, 64'd3);

        // Back-to-back single-byte sequences
        cp_data  = 32'h41;
        mode     = 2'd0;
        cp_valid = 1'b1;
        check("b2b_rdy0", {63'd0, cp_ready}, 64'd1);
        step();
        cp_data = 32'h42;
        check("b2b_d0", {56'd0, byte_data}, 64'h41);
        check("b2b_rdy1", {63'd0, cp_ready}, 64'd1);
        step();
        cp_data = 32'h43;
        check("b2b_d1", {56'd0, byte_data}, 64'h42);
        check("b2b_v1", {63'd0, byte_valid}, 64'd1);
        step();
        cp_valid = 1'b0;
        check("b2b_d2", {56'd0, byte_data}, 64'h43);
        check("b2b_f2", {63'd0, byte_first & byte_last}, 64'd1);
        step();
        check("b2b_idle", {63'd0, byte_valid}, 64'd0);

        // Reset in the middle of a UTF-32 sequence
        send_cp(32'h1F600, 2'd3, 1'b1);
        check("mid_b0", {56'd0, byte_data}, 64'h00);
        step();
        check("mid_b1", {56'd0, byte_data}, 64'h01);
        rst = 1'b1;
        step();
        check("mid_rst_vld",  {63'd0, byte_valid}, 64'd0);
        check("mid_rst_errc", {56'd0, err_count}, 64'd0);
        check("mid_rst_rdy",  {63'd0, cp_ready}, 64'd1);
        rst = 1'b0;
        step();
        check("post_rst_vld", {63'd0, byte_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
